// File: rtl/dark_min_pkg.sv
// dark_min_pkg: shared state encoding, constants and width helper for the dark-channel sequencer.
// Contents: state_e (sequencer states), ALL_ONES (flush pixel source), clog2 (counter widths).
package dark_min_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_FIN
    } state_e;

    // Sliced down to DATA_WIDTH by users; flush pixels must never win the minimum.
    localparam logic [63:0] ALL_ONES = '1;

    // Never returns less than 1 so degenerate counters still have a legal width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/dark_min_tagger.sv
// dark_min_tagger: drops start-up filter beats, forwards exactly IMG_WIDTH*height beats with tags.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr_i           clears all counters before a frame
//   en_i            output path active (frame running past CLR)
//   height_i        latched frame height (already clamped)
//   vin_i, din_i    filter valid_out / data_out
//   valid_o, data_o registered output pixel
//   sof_o, eol_o, eof_o  frame/row tags, only with valid_o
//   full_o          all frame pixels have been forwarded
module dark_min_tagger
    import dark_min_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int MAX_H_W    = 11,
    parameter int SKIP_LEN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [MAX_H_W-1:0]    height_i,
    input  logic                  vin_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  eof_o,
    output logic                  full_o
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int SK_W  = clog2(SKIP_LEN + 1);

    logic [SK_W-1:0]       skip_q, skip_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [MAX_H_W-1:0]    row_q, row_d;
    logic                  full_q, full_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic                  beat, skipping, fwd, last_col, last_row;

    always_comb begin
        beat     = en_i & vin_i;
        skipping = skip_q != SK_W'(SKIP_LEN);
        // Once full, surplus filter beats (flush tail) are silently dropped.
        fwd      = beat & ~skipping & ~full_q;
        last_col = col_q == COL_W'(IMG_WIDTH - 1);
        last_row = row_q == height_i - MAX_H_W'(1);
        skip_d   = clr_i ? '0 : (beat & skipping) ? skip_q + SK_W'(1) : skip_q;
        col_d    = clr_i ? '0 : fwd ? (last_col ? '0 : col_q + COL_W'(1)) : col_q;
        row_d    = clr_i ? '0 : (fwd & last_col) ? row_q + MAX_H_W'(1) : row_q;
        full_d   = ~clr_i & (full_q | (fwd & last_col & last_row));
        valid_d  = fwd;
        data_d   = fwd ? din_i : data_q;
        sof_d    = fwd & (col_q == '0) & (row_q == '0);
        eol_d    = fwd & last_col;
        eof_d    = fwd & last_col & last_row;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            skip_q  <= skip_d;
            col_q   <= col_d;
            row_q   <= row_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sof_o   = sof_q;
    assign eol_o   = eol_q;
    assign eof_o   = eof_q;
    assign full_o  = full_q;

endmodule

// File: rtl/dark_min_seq.sv
// dark_min_seq: frame sequencer around a 3x3 minimum filter (clear, feed, flush, drain, tag).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, cfg_height        frame start pulse and height (latched, clamped to >=2)
//   in_valid, in_data, in_ready   upstream pixel handshake
//   flt_rst_n, flt_valid, flt_data   filter drive (registered)
//   flt_vout, flt_dout       filter output
//   out_valid, out_data, out_sof, out_eol, out_eof   tagged output stream
//   busy, done, err_tmo      status: running, completion pulse, sticky drain timeout
module dark_min_seq
    import dark_min_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int MAX_H_W    = 11,
    parameter int SKIP_LEN   = 0,
    parameter int FLUSH_LEN  = IMG_WIDTH + 2,
    parameter int DRAIN_TMO  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MAX_H_W-1:0]    cfg_height,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  flt_rst_n,
    output logic                  flt_valid,
    output logic [DATA_WIDTH-1:0] flt_data,
    input  logic                  flt_vout,
    input  logic [DATA_WIDTH-1:0] flt_dout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  done,
    output logic                  err_tmo
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int FL_W  = clog2(FLUSH_LEN + 1);
    localparam int TM_W  = clog2(DRAIN_TMO + 1);

    state_e                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [MAX_H_W-1:0]    row_q, row_d, h_q, h_d;
    logic [FL_W-1:0]       fl_q, fl_d;
    logic [TM_W-1:0]       tm_q, tm_d;
    logic                  err_q, err_d;
    logic                  frst_q, frst_d;
    logic                  fv_q, fv_d;
    logic [DATA_WIDTH-1:0] fd_q, fd_d;
    logic                  beat, last_col, full;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        h_d      = h_q;
        fl_d     = fl_q;
        tm_d     = tm_q;
        err_d    = err_q;
        frst_d   = 1'b1;
        fv_d     = 1'b0;
        fd_d     = fd_q;
        beat     = in_valid & (state_q == S_FEED);
        last_col = col_q == COL_W'(IMG_WIDTH - 1);
        case (state_q)
            S_IDLE: if (start) begin
                h_d     = (cfg_height < MAX_H_W'(2)) ? MAX_H_W'(2) : cfg_height;
                err_d   = 1'b0;
                frst_d  = 1'b0;
                state_d = S_CLR;
            end
            S_CLR: begin
                col_d   = '0;
                row_d   = '0;
                fl_d    = '0;
                tm_d    = '0;
                state_d = S_FEED;
            end
            S_FEED: if (beat) begin
                fv_d  = 1'b1;
                fd_d  = in_data;
                col_d = last_col ? '0 : col_q + COL_W'(1);
                row_d = last_col ? row_q + MAX_H_W'(1) : row_q;
                if (last_col && row_q == h_q - MAX_H_W'(1)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                fv_d = 1'b1;
                fd_d = ALL_ONES[DATA_WIDTH-1:0];
                fl_d = fl_q + FL_W'(1);
                if (fl_q == FL_W'(FLUSH_LEN - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                tm_d = tm_q + TM_W'(1);
                // Completion wins over a timeout landing in the same cycle.
                if (full) state_d = S_FIN;
                else if (tm_q == TM_W'(DRAIN_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            fl_q    <= '0;
            tm_q    <= '0;
            err_q   <= 1'b0;
            frst_q  <= 1'b0;
            fv_q    <= 1'b0;
            fd_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            fl_q    <= fl_d;
            tm_q    <= tm_d;
            err_q   <= err_d;
            frst_q  <= frst_d;
            fv_q    <= fv_d;
            fd_q    <= fd_d;
        end
    end

    // Output path stays live through FIN so a beat captured on the timeout cycle still emerges.
    dark_min_tagger #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMG_WIDTH (IMG_WIDTH),
        .MAX_H_W   (MAX_H_W),
        .SKIP_LEN  (SKIP_LEN)
    ) u_tagger (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == S_CLR),
        .en_i    (state_q != S_IDLE && state_q != S_CLR),
        .height_i(h_q),
        .vin_i   (flt_vout),
        .din_i   (flt_dout),
        .valid_o (out_valid),
        .data_o  (out_data),
        .sof_o   (out_sof),
        .eol_o   (out_eol),
        .eof_o   (out_eof),
        .full_o  (full)
    );

    assign in_ready  = state_q == S_FEED;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_FIN;
    assign err_tmo   = err_q;
    assign flt_rst_n = frst_q;
    assign flt_valid = fv_q;
    assign flt_data  = fd_q;

endmodule

// File: doc/dark_min_seq.md
Name: dark_min_seq

Overview:
- Frame-level sequencer for the 3x3 minimum (dark-channel) filter in the dehaze pipeline.
- Accepts a pixel stream from upstream under a valid/ready handshake and clears the filter before each frame.
- Feeds the filter, then injects flush pixels so the last rows emerge.
- Discards start-up outputs and emits exactly IMG_WIDTH*cfg_height tagged output pixels with sof/eol/eof.

Parameters:
DATA_WIDTH, 8, pixel width
IMG_WIDTH, 640, fixed line length; must equal the filter's line-buffer width
MAX_H_W, 11, width of the height config and row counters
SKIP_LEN, 0, filter output beats discarded at frame start
FLUSH_LEN, IMG_WIDTH+2, all-ones pixels injected after the last image pixel
DRAIN_TMO, 64, cycles allowed in DRAIN before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; honoured only in IDLE
cfg_height  in  MAX_H_W  rows per frame, latched on start; 0 or 1 treated as 2
in_valid  in  1  upstream pixel valid
in_data  in  DATA_WIDTH  upstream pixel
in_ready  out  1  high only in FEED
flt_rst_n  out  1  filter reset, active-low, registered
flt_valid  out  1  filter valid_in
flt_data  out  DATA_WIDTH  filter data_in
flt_vout  in  1  filter valid_out
flt_dout  in  DATA_WIDTH  filter data_out
out_valid  out  1  tagged output pixel valid
out_data  out  DATA_WIDTH  output pixel
out_sof  out  1  first pixel of frame, with out_valid
out_eol  out  1  last pixel of a row, with out_valid
out_eof  out  1  last pixel of frame, with out_valid
busy  out  1  high when not in IDLE
done  out  1  one-cycle pulse on frame completion
err_tmo  out  1  sticky drain-timeout flag; cleared on start

Behaviour:
- Reset values: all outputs 0 except flt_rst_n=0. flt_rst_n rises on the first clk edge after rst falls. State returns to IDLE.
- A mid-frame rst aborts the frame: counters clear and no done is issued.
- States: IDLE, CLR, FEED, FLUSH, DRAIN, FIN.
- IDLE: on start, latch cfg_height (clamped to ≥2), clear err_tmo, go to CLR.
- CLR: flt_rst_n=0 for exactly 1 cycle, then go to FEED.
- FEED: in_ready=1. A beat transfers when in_valid & in_ready. On each beat, flt_valid=1 and flt_data=in_data, registered (1-cycle latency). Gaps are allowed; flt_valid=0 on idle cycles.
- FEED exit: col counts 0..IMG_WIDTH-1 and row counts 0..H-1. The beat with col=IMG_WIDTH-1 and row=H-1 moves to FLUSH; in_ready drops in the same cycle as that transfer (registered, so it is low on the next cycle).
- FLUSH: flt_valid=1 every cycle with flt_data all-ones for FLUSH_LEN consecutive cycles, then go to DRAIN.
- Output path runs in every state except IDLE/CLR, and is push-only with no backpressure:
  - Count flt_vout beats.
  - The first SKIP_LEN beats are dropped.
  - The next IMG_WIDTH*H beats are forwarded with 1-cycle register latency: out_data=flt_dout plus tags from the output col/row counters.
  - Any beats after that are dropped.
- Tags: out_sof at out index 0; out_eol at out col IMG_WIDTH-1; out_eof at the final index.
- DRAIN:
  - When the forwarded count reaches IMG_WIDTH*H, go to FIN.
  - If DRAIN_TMO cycles pass first, set err_tmo and go to FIN.
  - A flt_vout arriving in the same cycle as the timeout is still forwarded.
- FIN: done=1 for 1 cycle, then go to IDLE.
- start outside IDLE is ignored. start is also ignored while rst is high.
- Counter widths: col uses clog2(IMG_WIDTH); the output index uses clog2(IMG_WIDTH)+MAX_H_W. There is no wrap within a frame.

Decomposition:
- Package dark_min_pkg:
  - state enum localparams
  - clog2 function
  - ALL_ONES constant
- Sub-module: dark_min_tagger, the output skip/forward/tag counter, which is separable from the input-side FSM.
- The filter itself is instantiated at the level above. This block only drives its ports.

Test Plan:
Use IMG_WIDTH=8 and a real filter instance attached for all scenarios.
1. Basic frame: reset, start, cfg_height=4, 32 pixels streamed with no gaps.
   - Expected: flt_rst_n low for 1 cycle after start; exactly 32 out_valid beats.
   - Expected: out_sof on beat 0, out_eol on beats 7/15/23/31, out_eof on beat 31; done 1 cycle later; err_tmo=0.
2. Gappy upstream: in_valid toggles 1-0-1 randomly.
   - Expected: flt_valid mirrors transfers only; output data is identical to scenario 1.
3. Height clamp: cfg_height=0.
   - Expected: exactly 16 outputs, with out_eof at beat 15.
4. Timeout: force flt_vout=0 after 10 forwarded beats.
   - Expected: err_tmo set after 64 DRAIN cycles, done pulses, then IDLE; a later start clears err_tmo.
5. Reset mid-FEED: assert rst after 12 pixels.
   - Expected: immediate IDLE, busy=0, in_ready=0, flt_rst_n=0, no done pulse; the next full frame passes as in scenario 1.
6. start during busy: pulse start while in FLUSH.
   - Expected: ignored; a single done pulse and no second frame.
